// File: rtl/if_pc_ctrl.sv
// Fetch-stage PC register with vectored, prioritised, nestable interrupts.
// Return PCs and the interrupted handler's priority are kept on an internal LIFO.
module if_pc_ctrl #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] VEC_BASE    = XLEN'(32'h0000_1000),
  parameter int              VEC_SHIFT   = 4,
  parameter int              STACK_DEPTH = 4,
  localparam int             DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    npc,
  input  logic               pc_write,
  input  logic               int_en,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               irq_ret,
  output logic [XLEN-1:0]    pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic [DEPTH_W-1:0] int_depth,
  output logic               int_active,
  output logic               ret_err
);

  localparam int PRIO_W = $clog2(NUM_IRQ + 1);
  localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [XLEN-1:0]    stack_pc   [STACK_DEPTH];
  logic [PRIO_W-1:0]  stack_prio [STACK_DEPTH];
  logic [PRIO_W-1:0]  cur_prio;
  logic [DEPTH_W-1:0] depth;

  logic               win_valid;
  logic [PRIO_W-1:0]  win_idx;
  logic [XLEN-1:0]    vec_pc;
  logic               do_ret;
  logic               do_entry;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;

  // Lowest requesting index wins; scanning downward leaves the lowest one last.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq[i]) begin
        win_valid = 1'b1;
        win_idx   = PRIO_W'(i);
      end
    end
  end

  assign vec_pc   = VEC_BASE + (XLEN'(win_idx) << VEC_SHIFT);
  assign do_ret   = irq_ret && (depth != '0);
  assign do_entry = !do_ret && int_en && win_valid && (win_idx < cur_prio) &&
                    (depth < DEPTH_W'(STACK_DEPTH));
  assign push_idx = IDX_W'(depth);
  assign pop_idx  = IDX_W'(depth - DEPTH_W'(1));

  // Each entry saves the interrupted PC and the priority that was running then.
  always_ff @(posedge clk) begin
    if (reset && do_entry) begin
      stack_pc[push_idx]   <= pc;
      stack_prio[push_idx] <= cur_prio;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc         <= RESET_PC;
      depth      <= '0;
      cur_prio   <= PRIO_W'(NUM_IRQ);
      irq_ack    <= '0;
      ret_err    <= 1'b0;
      int_active <= 1'b0;
    end else begin
      irq_ack <= '0;
      ret_err <= irq_ret && (depth == '0);
      if (do_ret) begin
        pc         <= stack_pc[pop_idx];
        cur_prio   <= stack_prio[pop_idx];
        depth      <= depth - DEPTH_W'(1);
        int_active <= (depth != DEPTH_W'(1));
      end else if (do_entry) begin
        pc         <= vec_pc;
        cur_prio   <= win_idx;
        depth      <= depth + DEPTH_W'(1);
        int_active <= 1'b1;
        irq_ack    <= NUM_IRQ'(1) << win_idx;
      end else if (pc_write) begin
        pc <= npc;
      end
    end
  end

  assign int_depth = depth;

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Self-checking bench for if_pc_ctrl (STACK_DEPTH=2): table-driven vectors plus
// hand sequences, expected results routed through a scoreboard queue.
module tb_if_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] npc = '0;
  logic        pc_write = 1'b0;
  logic        int_en = 1'b0;
  logic [3:0]  irq = '0;
  logic        irq_ret = 1'b0;
  logic [31:0] pc;
  logic [3:0]  irq_ack;
  logic [1:0]  int_depth;
  logic        int_active;
  logic        ret_err;

  int tests_run = 0;
  int tests_failed = 0;
  int step_no = 0;

  typedef struct {
    logic        rst;
    logic        pw;
    logic [31:0] npc;
    logic        ie;
    logic [3:0]  irq;
    logic        ret;
    logic [31:0] pc;
    logic [3:0]  ack;
    logic [1:0]  depth;
    logic        active;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  ack;
    logic [1:0]  depth;
    logic        active;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[14];

  if_pc_ctrl #(.STACK_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .npc(npc), .pc_write(pc_write), .int_en(int_en),
    .irq(irq), .irq_ret(irq_ret), .pc(pc), .irq_ack(irq_ack),
    .int_depth(int_depth), .int_active(int_active), .ret_err(ret_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests_run++;
    if (act !== expv) begin
      tests_failed++;
      $display("[TB] FAIL step%0d.%s: got %0h expected %0h", step_no, nm, act, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL step%0d.queue: got empty expected entry", step_no);
      return;
    end
    e = exp_q.pop_front();
    chk("pc", pc, e.pc);
    chk("irq_ack", 32'(irq_ack), 32'(e.ack));
    chk("int_depth", 32'(int_depth), 32'(e.depth));
    chk("int_active", 32'(int_active), 32'(e.active));
    chk("ret_err", 32'(ret_err), 32'(e.err));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset    = v.rst;
    pc_write = v.pw;
    npc      = v.npc;
    int_en   = v.ie;
    irq      = v.irq;
    irq_ret  = v.ret;
    exp_q.push_back('{v.pc, v.ack, v.depth, v.active, v.err});
    @(posedge clk);
    #1;
    step_no++;
    checkOutput();
  endtask

  initial begin
    //        rst pw npc           ie irq      ret  pc            ack      dep   act err
    tbl[0]  = '{0, 0, 32'h0,       0, 4'b0000, 0, 32'h0,        4'b0000, 2'd0, 0, 0};
    tbl[1]  = '{0, 0, 32'h0,       0, 4'b0000, 0, 32'h0,        4'b0000, 2'd0, 0, 0};
    tbl[2]  = '{1, 1, 32'h40,      0, 4'b0000, 0, 32'h40,       4'b0000, 2'd0, 0, 0};
    tbl[3]  = '{1, 0, 32'h80,      0, 4'b0000, 0, 32'h40,       4'b0000, 2'd0, 0, 0};
    tbl[4]  = '{1, 1, 32'h44,      1, 4'b0100, 0, 32'h1020,     4'b0100, 2'd1, 1, 0};
    tbl[5]  = '{1, 1, 32'h1024,    1, 4'b0000, 0, 32'h1024,     4'b0000, 2'd1, 1, 0};
    tbl[6]  = '{1, 0, 32'h0,       1, 4'b1000, 0, 32'h1024,     4'b0000, 2'd1, 1, 0};
    tbl[7]  = '{1, 0, 32'h0,       1, 4'b0001, 0, 32'h1000,     4'b0001, 2'd2, 1, 0};
    tbl[8]  = '{1, 1, 32'h1004,    1, 4'b1000, 0, 32'h1004,     4'b0000, 2'd2, 1, 0};
    tbl[9]  = '{1, 0, 32'h0,       1, 4'b0000, 1, 32'h1024,     4'b0000, 2'd1, 1, 0};
    tbl[10] = '{1, 0, 32'h0,       1, 4'b1000, 0, 32'h1024,     4'b0000, 2'd1, 1, 0};
    tbl[11] = '{1, 0, 32'h0,       1, 4'b0000, 1, 32'h40,       4'b0000, 2'd0, 0, 0};
    tbl[12] = '{1, 0, 32'h0,       1, 4'b0000, 1, 32'h40,       4'b0000, 2'd0, 0, 1};
    tbl[13] = '{1, 0, 32'h0,       1, 4'b0000, 0, 32'h40,       4'b0000, 2'd0, 0, 0};

    for (int i = 0; i < 14; i++) applyStimulus(tbl[i]);

    // Stack full: 3 -> 1 nest, 0 held pending until a return frees a slot.
    applyStimulus('{1, 0, 32'h0, 1, 4'b1000, 0, 32'h1030, 4'b1000, 2'd1, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0010, 0, 32'h1010, 4'b0010, 2'd2, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0011, 0, 32'h1010, 4'b0000, 2'd2, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0001, 1, 32'h1030, 4'b0000, 2'd1, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0001, 0, 32'h1000, 4'b0001, 2'd2, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0000, 0, 32'h1000, 4'b0000, 2'd2, 1, 0});

    // Reset mid-nest, then a stray return reports underflow.
    applyStimulus('{0, 0, 32'h0, 1, 4'b0000, 0, 32'h0, 4'b0000, 2'd0, 0, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0000, 1, 32'h0, 4'b0000, 2'd0, 0, 1});

    // Return and request together at depth 1: return first, tail-chain next cycle.
    applyStimulus('{1, 0, 32'h0, 1, 4'b0100, 0, 32'h1020, 4'b0100, 2'd1, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0001, 1, 32'h0,    4'b0000, 2'd0, 0, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0001, 0, 32'h1000, 4'b0001, 2'd1, 1, 0});
    applyStimulus('{1, 0, 32'h0, 1, 4'b0000, 1, 32'h0,    4'b0000, 2'd0, 0, 0});

    // Interrupts globally disabled, and pc wraps as a plain XLEN value.
    applyStimulus('{1, 0, 32'h0,         0, 4'b0001, 0, 32'h0,         4'b0000, 2'd0, 0, 0});
    applyStimulus('{1, 1, 32'hFFFF_FFFC, 0, 4'b0001, 0, 32'hFFFF_FFFC, 4'b0000, 2'd0, 0, 0});

    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard: got %0d leftover entries expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/if_pc_ctrl.md
# if_pc_ctrl

Parametrised fetch-stage program-counter register with vectored, prioritised, nestable interrupt entry and return. It holds the architectural fetch PC, takes the next PC from the branch/jump logic, and redirects to a per-source vector on interrupt. It saves and restores return PCs on an internal LIFO so interrupts can nest up to a configurable depth. It sits at the head of the pipeline and drives the instruction-memory address.

## Interface
- `XLEN`, default 32: PC width in bits.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NUM_IRQ`, default 4: number of interrupt sources, 1..16. Index 0 is the highest priority.
- `VEC_BASE`, default 32'h0000_1000: vector of source 0.
- `VEC_SHIFT`, default 4: vector spacing is `1 << VEC_SHIFT` bytes, so vector(i) = VEC_BASE + (i << VEC_SHIFT), truncated to XLEN.
- `STACK_DEPTH`, default 4: maximum nesting depth, 1..16.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `npc` in XLEN: next PC from the branch/jump logic.
- `pc_write` in 1: load `npc` (stall when 0).
- `int_en` in 1: global interrupt enable.
- `irq` in NUM_IRQ: level-sensitive requests.
- `irq_ret` in 1: return-from-interrupt strobe.
- `pc` out XLEN: current fetch PC.
- `irq_ack` out NUM_IRQ: one-hot acknowledge, 1-cycle pulse.
- `int_depth` out clog2(STACK_DEPTH+1): current nesting depth.
- `int_active` out 1: int_depth != 0.
- `ret_err` out 1: 1-cycle pulse when `irq_ret` arrives at depth 0.

## Operation
- State:
  - `pc` register.
  - Return stack of STACK_DEPTH entries. Each entry holds a return PC and a priority index.
  - Depth counter.
  - `cur_prio`: priority of the running handler. Equals NUM_IRQ when not in an interrupt, meaning every source may preempt.
- Winner: the lowest index i with irq[i]=1.
- Entry condition: `int_en` && winner exists && winner < cur_prio && depth < STACK_DEPTH.
- Requests that fail the entry condition stay pending and are not dropped. Re-evaluation is every cycle, since sources hold the level until acked and cleared.
- Per-edge priority when `reset` is high (the first rule that applies wins):
  - (1) `irq_ret` with depth>0: pop; `pc` <= popped PC; `cur_prio` <= priority of the new top entry, or NUM_IRQ if depth becomes 0; depth-1.
  - (2) Entry: push {pc, cur_prio}; `pc` <= vector(winner); `cur_prio` <= winner; depth+1; irq_ack[winner] <= 1.
  - (3) `pc_write`: `pc` <= `npc`.
  - (4) Otherwise: hold.
- The saved PC is the current `pc` value, not npc. The interrupted instruction is refetched on return.
- `irq_ret` at depth 0: no state change except ret_err <= 1. Rules (2)-(4) still evaluate in the same cycle.
- Entry ignores `pc_write`. A stalled fetch is still redirected.
- The stack never overflows, because depth==STACK_DEPTH blocks entry. Underflow is reported via ret_err only.

## Timing
- All outputs are registered. New `pc`, `irq_ack`, `int_depth`, `int_active` and `ret_err` appear in the cycle after the deciding edge.
- Latency is 1 cycle from an asserted irq (sampled at edge N) to the vector on `pc` after edge N.
- irq_ack is high for exactly that one cycle.
- Simultaneous `irq_ret` and a valid request: the return wins. The request is evaluated again next cycle against the restored cur_prio. A pending higher-priority request can therefore re-enter immediately (tail-chain) with a 1-cycle gap.
- Reset (reset==0 at an edge) overrides everything, including mid-nest:
  - pc = RESET_PC
  - depth = 0, cur_prio = NUM_IRQ
  - irq_ack = 0, ret_err = 0, int_active = 0
- Stack contents are don't-care after reset.
- Wrap-around: vector arithmetic and pc are mod 2^XLEN. No carry out.

## Test plan
- **Reset/load.** Reset low for 2 cycles → pc=0, depth=0. Release with pc_write=1, npc=0x40 → pc=0x40 next cycle. With pc_write=0 → pc holds.
- **Single entry/return.** pc=0x40, int_en=1, irq=4'b0100 → next cycle pc=0x1020, irq_ack=4'b0100 for 1 cycle, depth=1. Later irq_ret → pc=0x40, depth=0.
- **Nesting and blocking.**
  - In handler 2: irq=4'b0001 → preempt, pc=0x1000, depth=2.
  - irq=4'b1000 while cur_prio=0 → no entry.
  - Return twice → the PCs come back in LIFO order.
- **Stack full.** STACK_DEPTH=2, three nested sources 3→1→0 → the third is held pending. After one irq_ret, it enters on the following cycle.
- **Simultaneous events.**
  - irq_ret and irq[0] in the same cycle at depth 1 → return first, entry to 0x1000 one cycle later.
  - irq_ret at depth 0 → ret_err pulse, pc unchanged.
- **Reset mid-nest.** Depth 2, reset low → pc=RESET_PC, depth=0, int_active=0. A subsequent irq_ret → ret_err=1.
